// File: rtl/disp_scan_fmt.sv
// disp_scan_fmt
// Captures N_FIELDS binary values on a load strobe, converts each one to BCD
// with a sequential shift-and-add-3 converter, formats the result into a row
// of digit codes (leading-zero blanking, overflow dashes, separators) and then
// scans that row out one digit at a time for a seven-segment decoder.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   load       one-cycle capture strobe for val and lz_blank
//   val        packed field values, field i at val[BIN_W*(i+1)-1 : BIN_W*i]
//   lz_blank   per-field leading-zero blanking enable (captured with load)
//   blink_mask per-field blink enable (live)
//   dp_mask    per-position decimal point enable (live)
//   light      current scan position, 0 = leftmost
//   num        digit code: 0-9 digit, 11 dash, 12 blank
//   dot        decimal point, active-low
//   busy       conversion in progress
//   done       one-cycle pulse when new codes are committed to the display
module disp_scan_fmt #(
    parameter int N_FIELDS     = 3,
    parameter int FIELD_DIGITS = 2,
    parameter int SEP          = 1,
    parameter int BIN_W        = 7,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_DIV    = 128,
    localparam int N_DIG = N_FIELDS*FIELD_DIGITS + SEP*(N_FIELDS-1),
    localparam int LW    = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [N_FIELDS*BIN_W-1:0] val,
    input  logic [N_FIELDS-1:0]       lz_blank,
    input  logic [N_FIELDS-1:0]       blink_mask,
    input  logic [N_DIG-1:0]          dp_mask,
    output logic [LW-1:0]             light,
    output logic [3:0]                num,
    output logic                      dot,
    output logic                      busy,
    output logic                      done
);

    localparam int BW     = 4*FIELD_DIGITS;
    localparam int FW     = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int CW     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int DW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BKW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int STRIDE = FIELD_DIGITS + SEP;
    localparam int LIMIT  = 10**FIELD_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_F,
        SHIFT,
        COMMIT
    } state_t;

    state_t                      state_q, state_d;
    logic [FW-1:0]               fld_q, fld_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [N_FIELDS*BIN_W-1:0]   val_sh_q, val_sh_d;
    logic [N_FIELDS-1:0]         lz_sh_q, lz_sh_d;
    logic [BIN_W-1:0]            shift_q, shift_d;
    logic [BW-1:0]               bcd_q, bcd_d;
    logic [N_FIELDS-1:0]         ovf_q, ovf_d;
    logic [N_FIELDS*BW-1:0]      stage_q, stage_d;
    logic [N_DIG-1:0][3:0]       disp_q, disp_d;
    logic [DW-1:0]               div_q, div_d;
    logic [LW-1:0]               light_q, light_d;
    logic [BKW-1:0]              frame_q, frame_d;
    logic                        blink_q, blink_d;
    logic [3:0]                  num_q, num_d;
    logic                        dot_q, dot_d;

    logic [BIN_W-1:0]            cur_field;
    logic [31:0]                 field_wide;
    logic [BW-1:0]               bcd_adj;
    logic [BW-1:0]               bcd_shift;
    logic [N_DIG-1:0][3:0]       fmt;
    logic [N_DIG-1:0]            blink_pos;
    logic                        lead;
    logic [3:0]                  nib;

    // One double-dabble step: every BCD nibble of 5 or more gets +3 so that
    // the following left shift carries correctly into the next decade.
    always_comb begin
        cur_field  = val_sh_q[int'(fld_q)*BIN_W +: BIN_W];
        field_wide = 32'(cur_field);
        bcd_adj    = bcd_q;
        for (int i = 0; i < FIELD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BW-2:0], shift_q[BIN_W-1]};
    end

    // Display image built from the staging slots. Digit 0 of a field is its
    // most significant digit; blanking stops at the first nonzero digit and
    // never touches the last digit, so a zero value still shows one 0.
    // blink_pos marks which scan positions belong to a blinking field.
    always_comb begin
        fmt       = {N_DIG{4'd12}};
        blink_pos = '0;
        lead      = 1'b0;
        nib       = 4'd0;
        for (int f = 0; f < N_FIELDS; f++) begin
            lead = lz_sh_q[f];
            for (int d = 0; d < FIELD_DIGITS; d++) begin
                nib = stage_q[f*BW + 4*(FIELD_DIGITS-1-d) +: 4];
                if (ovf_q[f]) begin
                    fmt[f*STRIDE+d] = 4'd11;
                end else if (lead && (nib == 4'd0) && (d != FIELD_DIGITS-1)) begin
                    fmt[f*STRIDE+d] = 4'd12;
                end else begin
                    fmt[f*STRIDE+d] = nib;
                    lead = 1'b0;
                end
                blink_pos[f*STRIDE+d] = blink_mask[f];
            end
            if ((SEP != 0) && (f < N_FIELDS-1)) begin
                fmt[f*STRIDE+FIELD_DIGITS] = 4'd11;
            end
        end
    end

    // Converter FSM. A load is accepted in every state and always restarts
    // from field 0; the display registers only change in COMMIT, so an
    // abandoned conversion never reaches the screen.
    always_comb begin
        state_d  = state_q;
        fld_d    = fld_q;
        cnt_d    = cnt_q;
        val_sh_d = val_sh_q;
        lz_sh_d  = lz_sh_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        stage_d  = stage_q;
        disp_d   = disp_q;

        case (state_q)
            IDLE: begin
            end
            LOAD_F: begin
                shift_d       = cur_field;
                bcd_d         = '0;
                ovf_d[fld_q]  = (field_wide >= 32'(LIMIT));
                cnt_d         = '0;
                state_d       = SHIFT;
            end
            SHIFT: begin
                bcd_d   = bcd_shift;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W-1)) begin
                    stage_d[int'(fld_q)*BW +: BW] = bcd_shift;
                    if (fld_q == FW'(N_FIELDS-1)) begin
                        state_d = COMMIT;
                    end else begin
                        fld_d   = fld_q + FW'(1);
                        state_d = LOAD_F;
                    end
                end
            end
            COMMIT: begin
                disp_d  = fmt;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            val_sh_d = val;
            lz_sh_d  = lz_blank;
            fld_d    = '0;
            state_d  = LOAD_F;
        end
    end

    // Free-running scan: the divider paces the position counter, each wrap
    // of the position counter is one frame, and the blink phase flips every
    // BLINK_DIV frames. The output registers are loaded from the next-state
    // values so a commit or a mask change shows up on the very next cycle.
    always_comb begin
        div_d   = div_q + DW'(1);
        light_d = light_q;
        frame_d = frame_q;
        blink_d = blink_q;
        if (div_q == DW'(SCAN_DIV-1)) begin
            div_d = '0;
            if (light_q == LW'(N_DIG-1)) begin
                light_d = '0;
                if (frame_q == BKW'(BLINK_DIV-1)) begin
                    frame_d = '0;
                    blink_d = ~blink_q;
                end else begin
                    frame_d = frame_q + BKW'(1);
                end
            end else begin
                light_d = light_q + LW'(1);
            end
        end

        if (blink_d && blink_pos[light_d]) begin
            num_d = 4'd12;
        end else begin
            num_d = disp_d[light_d];
        end
        dot_d = ~dp_mask[light_d];
    end

    // State register; reset blanks the display and aborts any conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fld_q    <= '0;
            cnt_q    <= '0;
            val_sh_q <= '0;
            lz_sh_q  <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
            ovf_q    <= '0;
            stage_q  <= '0;
            disp_q   <= {N_DIG{4'd12}};
            div_q    <= '0;
            light_q  <= '0;
            frame_q  <= '0;
            blink_q  <= 1'b0;
            num_q    <= 4'd12;
            dot_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            fld_q    <= fld_d;
            cnt_q    <= cnt_d;
            val_sh_q <= val_sh_d;
            lz_sh_q  <= lz_sh_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            stage_q  <= stage_d;
            disp_q   <= disp_d;
            div_q    <= div_d;
            light_q  <= light_d;
            frame_q  <= frame_d;
            blink_q  <= blink_d;
            num_q    <= num_d;
            dot_q    <= dot_d;
        end
    end

    assign light = light_q;
    assign num   = num_q;
    assign dot   = dot_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == COMMIT);

endmodule

// File: tb/tb_disp_scan_fmt.sv
// tb_disp_scan_fmt
// Drives a time-layout instance (3 fields, 2 digits, separators) and a
// year-layout instance (2 fields, 4 digits, no separators). Each load pushes
// its hand-computed display image onto a queue; a monitor per instance pops
// on done, checks the latency and then checks one full scan frame.
module tb_disp_scan_fmt;

    typedef struct packed {
        logic [31:0] img;
        logic [31:0] lat;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        load;
    logic [20:0] val;
    logic [2:0]  lz;
    logic [2:0]  blink_mask;
    logic [7:0]  dp_mask;
    logic [2:0]  light;
    logic [3:0]  num;
    logic        dot;
    logic        busy;
    logic        done;

    logic        load_y;
    logic [27:0] val_y;
    logic [1:0]  lz_y;
    logic [1:0]  blink_y;
    logic [7:0]  dp_y;
    logic [2:0]  light_y;
    logic [3:0]  num_y;
    logic        dot_y;
    logic        busy_y;
    logic        done_y;

    int checks;
    int failures;
    int cyc;
    int rst_cyc;
    int load_cyc;
    int load_cyc_y;
    int done_seen;
    int done_seen_y;

    exp_t exp_q[$];
    exp_t exp_y_q[$];

    disp_scan_fmt #(
        .N_FIELDS(3), .FIELD_DIGITS(2), .SEP(1), .BIN_W(7),
        .SCAN_DIV(4), .BLINK_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .val(val), .lz_blank(lz),
        .blink_mask(blink_mask), .dp_mask(dp_mask), .light(light),
        .num(num), .dot(dot), .busy(busy), .done(done)
    );

    disp_scan_fmt #(
        .N_FIELDS(2), .FIELD_DIGITS(4), .SEP(0), .BIN_W(14),
        .SCAN_DIV(4), .BLINK_DIV(2)
    ) dut_y (
        .clk(clk), .rst_n(rst_n), .load(load_y), .val(val_y), .lz_blank(lz_y),
        .blink_mask(blink_y), .dp_mask(dp_y), .light(light_y),
        .num(num_y), .dot(dot_y), .busy(busy_y), .done(done_y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle bookkeeping: rst_cyc is the first cycle after the last reset
    // edge, load_cyc is the cycle whose closing edge accepted a load.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) rst_cyc <= cyc + 1;
        if (load && rst_n) load_cyc <= cyc;
        if (load_y && rst_n) load_cyc_y <= cyc;
    end

    // Scan model shared by both instances (SCAN_DIV=4, 8 positions,
    // BLINK_DIV=2 so the phase flips every 64 cycles).
    function automatic int model_light();
        return ((cyc - rst_cyc) / 4) % 8;
    endfunction

    function automatic int model_blink();
        return ((cyc - rst_cyc) / 64) % 2;
    endfunction

    function automatic logic [31:0] mk8(input int c0, input int c1, input int c2,
                                        input int c3, input int c4, input int c5,
                                        input int c6, input int c7);
        logic [31:0] r;
        r[3:0]   = 4'(c0);
        r[7:4]   = 4'(c1);
        r[11:8]  = 4'(c2);
        r[15:12] = 4'(c3);
        r[19:16] = 4'(c4);
        r[23:20] = 4'(c5);
        r[27:24] = 4'(c6);
        r[31:28] = 4'(c7);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Load the time instance; the image is queued only when a commit is due.
    task automatic applyStimulus(input int a, input int b, input int c,
                                 input logic [2:0] lzv, input logic [31:0] img,
                                 input bit expect_done);
        exp_t e;
        e.img = img;
        e.lat = 32'd25;
        @(negedge clk);
        if (expect_done) exp_q.push_back(e);
        val  = {7'(c), 7'(b), 7'(a)};
        lz   = lzv;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("busy_after_load", busy, 1);
    endtask

    task automatic applyStimulusYear(input int a, input int b, input logic [1:0] lzv,
                                     input logic [31:0] img);
        exp_t e;
        e.img = img;
        e.lat = 32'd31;
        @(negedge clk);
        exp_y_q.push_back(e);
        val_y  = {14'(b), 14'(a)};
        lz_y   = lzv;
        load_y = 1'b1;
        @(negedge clk);
        load_y = 1'b0;
        checkOutput("busy_y_after_load", busy_y, 1);
    endtask

    task automatic waitDone(input int target);
        int t;
        t = 0;
        while (done_seen < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        checkOutput("done_wait", 32'(done_seen >= target), 1);
    endtask

    task automatic waitDoneYear(input int target);
        int t;
        t = 0;
        while (done_seen_y < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        checkOutput("done_y_wait", 32'(done_seen_y >= target), 1);
    endtask

    // Monitor for the time instance.
    initial begin
        exp_t e;
        int ml;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("latency", 32'(cyc - load_cyc), e.lat);
                    checkOutput("busy_at_done", busy, 1);
                    for (int k = 0; k < 32; k++) begin
                        @(negedge clk);
                        ml = model_light();
                        if (k == 0) checkOutput("busy_after_done", busy, 0);
                        checkOutput("light", light, ml);
                        checkOutput("num", num, e.img[4*ml +: 4]);
                        checkOutput("dot", dot, 1);
                    end
                    done_seen++;
                end
            end
        end
    end

    // Monitor for the year instance.
    initial begin
        exp_t e;
        int ml;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done_y === 1'b1) begin
                if (exp_y_q.size() == 0) begin
                    checkOutput("unexpected_done_y", done_y, 0);
                end else begin
                    e = exp_y_q.pop_front();
                    checkOutput("latency_y", 32'(cyc - load_cyc_y), e.lat);
                    for (int k = 0; k < 32; k++) begin
                        @(negedge clk);
                        ml = model_light();
                        checkOutput("light_y", light_y, ml);
                        checkOutput("num_y", num_y, e.img[4*ml +: 4]);
                    end
                    done_seen_y++;
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] prev_img;
        logic [31:0] img_b;
        int ml;
        int exp_num;
        int done_cnt;

        rst_n      = 1'b0;
        load       = 1'b0;
        val        = '0;
        lz         = '0;
        blink_mask = '0;
        dp_mask    = '0;
        load_y     = 1'b0;
        val_y      = '0;
        lz_y       = '0;
        blink_y    = '0;
        dp_y       = '0;

        // Reset state, then one full frame of blanks.
        repeat (2) @(negedge clk);
        checkOutput("rst_light", light, 0);
        checkOutput("rst_num", num, 12);
        checkOutput("rst_dot", dot, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_num_y", num_y, 12);
        checkOutput("rst_busy_y", busy_y, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checkOutput("rst_scan_light", light, model_light());
            checkOutput("rst_scan_num", num, 12);
            checkOutput("rst_scan_num_y", num_y, 12);
        end

        // Time layout and blanking / overflow boundaries.
        applyStimulus(23, 59, 7, 3'b000, mk8(2, 3, 11, 5, 9, 11, 0, 7), 1'b1);
        waitDone(1);
        applyStimulus(23, 59, 5, 3'b111, mk8(2, 3, 11, 5, 9, 11, 12, 5), 1'b1);
        waitDone(2);
        applyStimulus(5, 100, 0, 3'b101, mk8(12, 5, 11, 11, 11, 11, 12, 0), 1'b1);
        waitDone(3);
        prev_img = mk8(9, 9, 11, 12, 0, 11, 1, 0);
        applyStimulus(99, 0, 10, 3'b010, prev_img, 1'b1);
        waitDone(4);

        // Year layout, including a 4-digit overflow and an all-zero field.
        applyStimulusYear(2024, 113, 2'b10, mk8(2, 0, 2, 4, 12, 1, 1, 3));
        waitDoneYear(1);
        applyStimulusYear(12345, 0, 2'b11, mk8(11, 11, 11, 11, 12, 12, 12, 0));
        waitDoneYear(2);

        // Restart: A is abandoned, only B commits; old image holds meanwhile.
        img_b = mk8(0, 4, 11, 0, 5, 11, 0, 6);
        applyStimulus(1, 2, 3, 3'b000, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        applyStimulus(4, 5, 6, 3'b000, img_b, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ml = model_light();
            checkOutput("restart_old_num", num, prev_img[4*ml +: 4]);
        end
        waitDone(5);

        // Blink on field 1 and a decimal point at position 4.
        @(negedge clk);
        blink_mask = 3'b010;
        dp_mask    = 8'h10;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            ml      = model_light();
            exp_num = int'(img_b[4*ml +: 4]);
            if (model_blink() == 1 && (ml == 3 || ml == 4)) exp_num = 12;
            checkOutput("blink_num", num, exp_num);
            checkOutput("blink_dot", dot, (ml == 4) ? 0 : 1);
        end
        blink_mask = 3'b000;
        dp_mask    = 8'h00;

        // Reset mid-conversion, with load asserted alongside reset.
        applyStimulus(1, 2, 3, 3'b000, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b1;
        val   = {7'd9, 7'd8, 7'd7};
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            checkOutput("abort_num", num, 12);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_light", light, model_light());
        end
        checkOutput("abort_done_count", done_cnt, 0);

        checkOutput("scoreboard_empty", 32'(exp_q.size() + exp_y_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
